// File: rtl/bp_me_pkg.sv
// Shared types and constants for the hybrid CCE memory-side pipes.
// Holds the arbiter state encoding and default stream widths.
package bp_me_pkg;

    typedef enum logic {
        e_arb_ready,
        e_arb_busy
    } bp_arb_state_e;

    localparam int arb_sources_gp              = 2;
    localparam int dword_width_gp              = 64;
    localparam int cce_mem_msg_header_width_gp = 56;

endpackage

// File: rtl/bp_cce_hybrid_credit_counter.sv
// Up/down saturating credit counter shared by the hybrid CCE pipes.
// Simultaneous take and return leave the count unchanged.
module bp_cce_hybrid_credit_counter #(
    parameter int max_p = 8,
    parameter int cw_p  = $clog2(max_p + 1)
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [cw_p-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [cw_p-1:0] r_cnt;

    assign count_o = r_cnt;
    assign full_o  = (r_cnt == cw_p'(max_p));
    assign empty_o = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/bp_cce_hybrid_mem_cmd_arb.sv
// Merges uncached (port 0) and coherent (port 1) memory command streams.
// Define BP_CCE_HYBRID_MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module bp_cce_hybrid_mem_cmd_arb
    import bp_me_pkg::*;
#(
    parameter int cce_mem_msg_header_width_lp = cce_mem_msg_header_width_gp,
    parameter int mem_data_width_p            = dword_width_gp,
    parameter int credits_p                   = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    output logic                                   empty_o,
    input  logic [cce_mem_msg_header_width_lp-1:0] uc_cmd_header_i,
    input  logic [mem_data_width_p-1:0]            uc_cmd_data_i,
    input  logic                                   uc_cmd_v_i,
    input  logic                                   uc_cmd_last_i,
    output logic                                   uc_cmd_ready_and_o,
    input  logic [cce_mem_msg_header_width_lp-1:0] coh_cmd_header_i,
    input  logic [mem_data_width_p-1:0]            coh_cmd_data_i,
    input  logic                                   coh_cmd_v_i,
    input  logic                                   coh_cmd_last_i,
    output logic                                   coh_cmd_ready_and_o,
    output logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_o,
    output logic [mem_data_width_p-1:0]            mem_cmd_data_o,
    output logic                                   mem_cmd_v_o,
    output logic                                   mem_cmd_last_o,
    input  logic                                   mem_cmd_ready_and_i,
    input  logic                                   credit_return_i
);

    localparam int cw_lp = $clog2(credits_p + 1);

    bp_arb_state_e    r_state;
    bp_arb_state_e    w_state_nxt;
    logic             r_grant;
    logic             w_grant_nxt;
    logic             r_first;
    logic             w_choice;
    logic             w_sel;
    logic             w_en;
    logic             w_sel_v;
    logic             w_sel_last;
    logic             w_hs;
    logic             w_full;
    logic             w_cnt_empty;
    logic [cw_lp-1:0] w_credits;

`ifdef BP_CCE_HYBRID_MEM_ARB_FIXED_PRIO_EN
    assign w_choice = ~uc_cmd_v_i & coh_cmd_v_i;
`else
    logic r_last;

    // On a tie the source not granted last wins.
    assign w_choice = (uc_cmd_v_i & coh_cmd_v_i) ? ~r_last : coh_cmd_v_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last <= 1'b1;
        end else if (w_hs && mem_cmd_last_o) begin
            r_last <= w_sel;
        end
    end
`endif

    assign w_sel = (r_state == e_arb_busy) ? r_grant : w_choice;

    // Full credits only block new messages; a held grant always drains.
    assign w_en = reset_n_i & ((r_state == e_arb_busy) | ~w_full);

    assign w_sel_v    = w_sel ? coh_cmd_v_i    : uc_cmd_v_i;
    assign w_sel_last = w_sel ? coh_cmd_last_i : uc_cmd_last_i;

    assign mem_cmd_v_o    = w_en & w_sel_v;
    assign mem_cmd_last_o = w_en & w_sel_last;

    assign mem_cmd_header_o = !w_en ? '0
                            : w_sel ? coh_cmd_header_i
                            : uc_cmd_header_i;
    assign mem_cmd_data_o   = !w_en ? '0
                            : w_sel ? coh_cmd_data_i
                            : uc_cmd_data_i;

    assign uc_cmd_ready_and_o  = w_en & ~w_sel & mem_cmd_ready_and_i;
    assign coh_cmd_ready_and_o = w_en &  w_sel & mem_cmd_ready_and_i;

    assign w_hs = mem_cmd_v_o & mem_cmd_ready_and_i;

    assign empty_o = (r_state == e_arb_ready) & w_cnt_empty
                   & ~uc_cmd_v_i & ~coh_cmd_v_i;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            e_arb_ready: begin
                if (mem_cmd_v_o && !(w_hs && mem_cmd_last_o)) begin
                    w_state_nxt = e_arb_busy;
                    w_grant_nxt = w_sel;
                end
            end
            e_arb_busy: begin
                if (w_hs && mem_cmd_last_o) begin
                    w_state_nxt = e_arb_ready;
                end
            end
            default: w_state_nxt = e_arb_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_arb_ready;
            r_grant <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_hs) begin
                r_first <= mem_cmd_last_o;
            end
        end
    end

    bp_cce_hybrid_credit_counter #(
        .max_p (credits_p),
        .cw_p  (cw_lp)
    ) u_credits (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (w_hs & r_first),
        .dec_i     (credit_return_i),
        .count_o   (w_credits),
        .full_o    (w_full),
        .empty_o   (w_cnt_empty)
    );

`ifndef SYNTHESIS
    logic [cce_mem_msg_header_width_lp-1:0] r_hdr_chk;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hdr_chk <= '0;
        end else begin
            if (credit_return_i) begin
                assert (w_credits != '0);
            end
            if (w_hs) begin
                if (!r_first) begin
                    assert (mem_cmd_header_o == r_hdr_chk);
                end
                r_hdr_chk <= mem_cmd_header_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_mem_cmd_arb.sv
// Randomized bench for the hybrid CCE memory command arbiter.
// A message-level model predicts grants, handshakes and credit use.
module tb_bp_cce_hybrid_mem_cmd_arb;

    localparam int HW   = 32;
    localparam int DW   = 64;
    localparam int CRED = 2;
`ifdef BP_CCE_HYBRID_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty;
    logic [HW-1:0] uc_h, coh_h, m_h;
    logic [DW-1:0] uc_d, coh_d, m_d;
    logic          uc_v, uc_last, uc_rdy;
    logic          coh_v, coh_last, coh_rdy;
    logic          m_v, m_last, m_rdy, cret;

    always #5 clk = ~clk;

    bp_cce_hybrid_mem_cmd_arb #(
        .cce_mem_msg_header_width_lp (HW),
        .mem_data_width_p            (DW),
        .credits_p                   (CRED)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (rst_n),
        .empty_o             (empty),
        .uc_cmd_header_i     (uc_h),
        .uc_cmd_data_i       (uc_d),
        .uc_cmd_v_i          (uc_v),
        .uc_cmd_last_i       (uc_last),
        .uc_cmd_ready_and_o  (uc_rdy),
        .coh_cmd_header_i    (coh_h),
        .coh_cmd_data_i      (coh_d),
        .coh_cmd_v_i         (coh_v),
        .coh_cmd_last_i      (coh_last),
        .coh_cmd_ready_and_o (coh_rdy),
        .mem_cmd_header_o    (m_h),
        .mem_cmd_data_o      (m_d),
        .mem_cmd_v_o         (m_v),
        .mem_cmd_last_o      (m_last),
        .mem_cmd_ready_and_i (m_rdy),
        .credit_return_i     (cret)
    );

    typedef struct {
        logic [HW-1:0] hdr;
        int            beats;
    } msg_t;

    msg_t qu[$];
    msg_t qc[$];
    int   beat[2];
    bit   pres[2];
    int   rate[2];
    int   rdy_rate, ret_rate;

    // Model: current message owner (-1 none), last winner, messages in flight.
    int   owner, prev, outst;
    int   grants[$];

    bit            e_v, e_r0, e_r1, e_empty, e_last;
    int            e_sel;
    logic [HW-1:0] e_h;
    logic [DW-1:0] e_d;

    int errors = 0;
    int checks = 0;

    function automatic int qsize(int p);
        return (p == 0) ? qu.size() : qc.size();
    endfunction

    function automatic msg_t head(int p);
        return (p == 0) ? qu[0] : qc[0];
    endfunction

    function automatic void push_msg(int p, int nb);
        msg_t m;
        m.hdr   = $urandom;
        m.beats = nb;
        if (p == 0) qu.push_back(m);
        else        qc.push_back(m);
    endfunction

    task automatic drive();
        msg_t m;
        uc_v = pres[0];
        coh_v = pres[1];
        uc_h = '0; uc_d = '0; uc_last = 1'b0;
        coh_h = '0; coh_d = '0; coh_last = 1'b0;
        if (qu.size() > 0) begin
            m = qu[0];
            uc_h = m.hdr;
            uc_d = {m.hdr, 32'(beat[0])};
            uc_last = (beat[0] == m.beats - 1);
        end
        if (qc.size() > 0) begin
            m = qc[0];
            coh_h = m.hdr;
            coh_d = {m.hdr, 32'(beat[1])};
            coh_last = (beat[1] == m.beats - 1);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        qu.delete(); qc.delete(); grants.delete();
        beat[0] = 0; beat[1] = 0; pres[0] = 0; pres[1] = 0;
        owner = -1; prev = 1; outst = 0;
        m_rdy = 1'b0; cret = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Compute expected outputs from the model at the negedge.
    task automatic sample();
        bit en;
        msg_t m;
        @(negedge clk);
        if (owner >= 0) begin
            en = 1; e_sel = owner;
        end else begin
            en = (outst < CRED);
            if (pres[0] && pres[1]) e_sel = FIXED ? 0 : ((prev == 0) ? 1 : 0);
            else e_sel = (pres[1] && !pres[0]) ? 1 : 0;
        end
        e_v = en && pres[e_sel];
        e_r0 = en && (e_sel == 0) && m_rdy;
        e_r1 = en && (e_sel == 1) && m_rdy;
        e_empty = (owner < 0) && (outst == 0) && !pres[0] && !pres[1];
        e_h = '0; e_d = '0; e_last = 0;
        if (e_v) begin
            m = head(e_sel);
            e_h = m.hdr;
            e_d = {m.hdr, 32'(beat[e_sel])};
            e_last = (beat[e_sel] == m.beats - 1);
        end
    endtask

    // Clock the model forward and draw new stimulus.
    task automatic advance();
        bit hs;
        @(posedge clk);
        hs = e_v && m_rdy;
        if (hs) begin
            grants.push_back(e_sel);
            if (beat[e_sel] == 0) outst++;
            if (e_last) begin
                owner = -1; prev = e_sel;
            end else begin
                owner = e_sel;
            end
            beat[e_sel]++;
            pres[e_sel] = 0;
            if (beat[e_sel] == head(e_sel).beats) begin
                beat[e_sel] = 0;
                if (e_sel == 0) void'(qu.pop_front());
                else            void'(qc.pop_front());
            end
        end else if (e_v) begin
            owner = e_sel;
        end
        if (cret) outst--;
        #1;
        for (int p = 0; p < 2; p++)
            if (!pres[p] && qsize(p) > 0 && $urandom_range(99) < rate[p])
                pres[p] = 1;
        m_rdy = ($urandom_range(99) < rdy_rate);
        cret = (outst > 0) && ($urandom_range(99) < ret_rate);
        drive();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pres[0] = 0; pres[1] = 0;
        qu.delete(); qc.delete();
        m_rdy = 1'b1; cret = 1'b0;
        drive();
        #2;
        checks++;
        if ({m_v, uc_rdy, coh_rdy, empty, m_h, m_d} !== {4'b0001, {HW{1'b0}}, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_idle got v=%b r=%b%b e=%b h=%h", m_v, uc_rdy, coh_rdy, empty, m_h);
        end
        push_msg(0, 1);
        pres[0] = 1;
        drive();
        #2;
        checks++;
        if ({m_v, uc_rdy, coh_rdy, empty} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gated got %b exp 0000", {m_v, uc_rdy, coh_rdy, empty});
        end
        apply_reset();
        checks++;
        if (dut.u_credits.count_o !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release cnt=%0d empty=%b exp 0/1", dut.u_credits.count_o, empty);
        end
    endtask

    task automatic test_single();
        apply_reset();
        rate[0] = 100; rate[1] = 100; rdy_rate = 100; ret_rate = 0;
        push_msg(0, 1);
        pres[0] = 1; m_rdy = 1;
        drive();
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL single_ctl c=%0d got %b exp %b", i, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            if (e_v) begin
                checks++;
                if ({m_h, m_d, m_last} !== {e_h, e_d, e_last}) begin
                    errors++;
                    $display("FAIL single_data got %h/%b exp %h/%b", m_h, m_last, e_h, e_last);
                end
            end
            advance();
        end
        checks++;
        if (dut.u_credits.count_o !== 1 || dut.r_state !== bp_me_pkg::e_arb_ready) begin
            errors++;
            $display("FAIL single_credit cnt=%0d state=%0d exp 1/0", dut.u_credits.count_o, dut.r_state);
        end
    endtask

    task automatic test_alternate();
        int ex;
        apply_reset();
        rate[0] = 100; rate[1] = 100; rdy_rate = 100; ret_rate = 100;
        for (int i = 0; i < 4; i++) begin
            push_msg(0, 1);
            push_msg(1, 1);
        end
        pres[0] = 1; pres[1] = 1; m_rdy = 1;
        drive();
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL alt_ctl c=%0d got %b exp %b", i, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            if (e_v) begin
                checks++;
                if ({m_h, m_d, m_last} !== {e_h, e_d, e_last}) begin
                    errors++;
                    $display("FAIL alt_data got %h exp %h", m_h, e_h);
                end
            end
            advance();
        end
        checks++;
        if (grants.size() != 8) begin
            errors++;
            $display("FAIL alt_count got %0d exp 8", grants.size());
        end
        for (int i = 0; i < grants.size() && i < 8; i++) begin
            ex = FIXED ? ((i < 4) ? 0 : 1) : (i % 2);
            checks++;
            if (grants[i] != ex) begin
                errors++;
                $display("FAIL alt_order i=%0d got %0d exp %0d", i, grants[i], ex);
            end
        end
    endtask

    task automatic test_multibeat();
        bit pushed = 0;
        apply_reset();
        rate[0] = 100; rate[1] = 100; rdy_rate = 100; ret_rate = 0;
        push_msg(0, 8);
        pres[0] = 1; m_rdy = 1;
        drive();
        for (int i = 0; i < 12; i++) begin
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL multi_ctl c=%0d got %b exp %b", i, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            if (e_v) begin
                checks++;
                if ({m_h, m_d, m_last} !== {e_h, e_d, e_last}) begin
                    errors++;
                    $display("FAIL multi_data c=%0d got %h/%h exp %h/%h", i, m_h, m_d, e_h, e_d);
                end
            end
            advance();
            if (!pushed && grants.size() == 2) begin
                pushed = 1;
                push_msg(1, 1);
                pres[1] = 1;
                drive();
            end
        end
        checks++;
        if (grants.size() != 9 || dut.u_credits.count_o !== 2) begin
            errors++;
            $display("FAIL multi_count beats=%0d cnt=%0d exp 9/2", grants.size(), dut.u_credits.count_o);
        end
        for (int i = 0; i < grants.size() && i < 9; i++) begin
            checks++;
            if (grants[i] != ((i < 8) ? 0 : 1)) begin
                errors++;
                $display("FAIL multi_order i=%0d got %0d exp %0d", i, grants[i], (i < 8) ? 0 : 1);
            end
        end
    endtask

    task automatic test_credits();
        apply_reset();
        rate[0] = 100; rate[1] = 100; rdy_rate = 100; ret_rate = 0;
        for (int i = 0; i < 3; i++) push_msg(0, 1);
        pres[0] = 1; m_rdy = 1;
        drive();
        for (int i = 0; i < 9; i++) begin
            ret_rate = (i == 4 || i == 5) ? 100 : 0;
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL cred_ctl c=%0d got %b exp %b", i, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            if (i == 3) begin
                checks++;
                if (m_v !== 1'b0 || dut.u_credits.count_o !== 2) begin
                    errors++;
                    $display("FAIL cred_full v=%b cnt=%0d exp 0/2", m_v, dut.u_credits.count_o);
                end
            end
            advance();
        end
        checks++;
        if (dut.u_credits.count_o !== 1 || grants.size() != 3) begin
            errors++;
            $display("FAIL cred_simul cnt=%0d sent=%0d exp 1/3", dut.u_credits.count_o, grants.size());
        end
    endtask

    task automatic test_backpressure();
        logic [HW-1:0] h0;
        apply_reset();
        rate[0] = 100; rate[1] = 100; rdy_rate = 0; ret_rate = 0;
        push_msg(1, 2);
        h0 = qc[0].hdr;
        pres[1] = 1; m_rdy = 0;
        drive();
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                push_msg(0, 1);
                pres[0] = 1;
                drive();
            end
            rdy_rate = (i >= 4) ? 100 : 0;
            ret_rate = (i >= 4) ? 100 : 0;
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL bp_ctl c=%0d got %b exp %b", i, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            if (i < 5) begin
                checks++;
                if (m_h !== h0 || m_v !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d got %h/%b exp %h/1", i, m_h, m_v, h0);
                end
            end
            advance();
        end
        checks++;
        if (grants.size() != 3 || grants[0] != 1 || grants[1] != 1 || grants[2] != 0) begin
            errors++;
            $display("FAIL bp_order got n=%0d exp 1,1,0", grants.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        rate[0] = 70; rate[1] = 70; rdy_rate = 70; ret_rate = 40;
        for (int i = 0; i < 30; i++) begin
            push_msg(0, $urandom_range(1, 8));
            push_msg(1, $urandom_range(1, 8));
        end
        for (int c = 0; c < 3000 && (qu.size() > 0 || qc.size() > 0); c++) begin
            rate[0] = $urandom_range(30, 100);
            rate[1] = $urandom_range(30, 100);
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got %b exp %b", c, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            if (e_v) begin
                checks++;
                if ({m_h, m_d, m_last} !== {e_h, e_d, e_last}) begin
                    errors++;
                    $display("FAIL rand_data c=%0d got %h/%b exp %h/%b", c, m_h, m_last, e_h, e_last);
                end
            end
            advance();
        end
        checks++;
        if (qu.size() != 0 || qc.size() != 0) begin
            errors++;
            $display("FAIL rand_drain left=%0d exp 0", qu.size() + qc.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rate[0] = 100; rate[1] = 100; rdy_rate = 100; ret_rate = 0;
        push_msg(0, 8);
        pres[0] = 1; m_rdy = 1;
        drive();
        for (int i = 0; i < 20 && grants.size() < 3; i++) begin
            sample();
            checks++;
            if ({m_v, uc_rdy, coh_rdy, empty} !== {e_v, e_r0, e_r1, e_empty}) begin
                errors++;
                $display("FAIL mid_ctl c=%0d got %b exp %b", i, {m_v, uc_rdy, coh_rdy, empty}, {e_v, e_r0, e_r1, e_empty});
            end
            advance();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_v, uc_rdy, coh_rdy, m_last, m_h, m_d} !== '0) begin
            errors++;
            $display("FAIL mid_async got v=%b r=%b%b h=%h exp all 0", m_v, uc_rdy, coh_rdy, m_h);
        end
        qu.delete(); pres[0] = 0; beat[0] = 0;
        owner = -1; prev = 1; outst = 0;
        m_rdy = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || dut.u_credits.count_o !== 0) begin
            errors++;
            $display("FAIL mid_after empty=%b cnt=%0d exp 1/0", empty, dut.u_credits.count_o);
        end
    endtask

    initial begin
        owner = -1; prev = 1; outst = 0;
        rate[0] = 0; rate[1] = 0; rdy_rate = 0; ret_rate = 0;
        beat[0] = 0; beat[1] = 0;
        test_reset();
        test_single();
        test_alternate();
        test_multibeat();
        test_credits();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_cce_hybrid_mem_cmd_arb.md
Name: bp_cce_hybrid_mem_cmd_arb

Overview:
Downstream neighbour of the hybrid CCE uncached pipe. It merges two BedRock Stream memory-command sources onto the single CCE memory-command port:
- port 0: the uncached pipe;
- port 1: the coherent pipe.
Arbitration is per message. Once a source wins, the grant is held until the last beat of its message. A credit counter bounds the number of outstanding memory commands.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies paddr/lce/cce widths and cce_mem_msg_header_width_lp.
mem_data_width_p, dword_width_gp, stream data beat width.
credits_p, 8, maximum outstanding memory commands (messages, not beats); must be >= 1.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; one clock; reset is asynchronous and active-low
empty_o  out  1  no message in flight through arbiter and zero outstanding credits
uc_cmd_header_i  in  cce_mem_msg_header_width_lp  port 0 header
uc_cmd_data_i  in  mem_data_width_p  port 0 beat data
uc_cmd_v_i  in  1  port 0 valid
uc_cmd_last_i  in  1  port 0 last beat
uc_cmd_ready_and_o  out  1  port 0 ready
coh_cmd_header_i  in  cce_mem_msg_header_width_lp  port 1 header
coh_cmd_data_i  in  mem_data_width_p  port 1 beat data
coh_cmd_v_i  in  1  port 1 valid
coh_cmd_last_i  in  1  port 1 last beat
coh_cmd_ready_and_o  out  1  port 1 ready
mem_cmd_header_o  out  cce_mem_msg_header_width_lp  merged header
mem_cmd_data_o  out  mem_data_width_p  merged data
mem_cmd_v_o  out  1  merged valid
mem_cmd_last_o  out  1  merged last
mem_cmd_ready_and_i  in  1  downstream ready
credit_return_i  in  1  one memory response fully consumed; frees one credit

Behaviour:
- Handshake: ready&valid on all ports; a beat transfers when v & ready_and are high in the same cycle.
- Datapath: zero latency. Output fields are combinational muxes of the selected source. The non-selected source sees ready_and_o = 0.
- mem_cmd_v_o never depends on mem_cmd_ready_and_i.
- State machine, two states:
  - e_ready (no grant held):
    - choice = round-robin over valid sources; priority goes to the source not granted last (last_r; reset value = 1, so uc wins the first tie).
    - If credits_used_r == credits_p, new messages are blocked: mem_cmd_v_o = 0 and both ready_and_o = 0.
    - Otherwise drive the chosen source.
    - Handshake with last = 1 (single-beat message): stay in e_ready, update last_r.
    - Handshake with last = 0, or valid without ready: latch grant_r = choice and go to e_busy.
  - e_busy:
    - Drive grant_r only; credit full does not gate any beat here.
    - Return to e_ready and set last_r = grant_r on the handshake where last = 1.
  - Once a first beat is presented, the grant is frozen. Output header/valid stay stable until accepted.
- Credits:
  - credits_used_r, width clog2(credits_p+1), reset 0.
  - +1 on the first-beat handshake of each message; first_r tracks first beat, reset 1.
  - −1 on credit_return_i.
  - Both in the same cycle: value unchanged.
  - credit_return_i while 0: ignored; simulation error.
- empty_o = (state_r == e_ready) & (credits_used_r == 0) & ~uc_cmd_v_i & ~coh_cmd_v_i.
- Reset values:
  - state e_ready, grant_r 0, last_r 1, first_r 1, credits 0.
  - Outputs during reset: mem_cmd_v_o 0, both ready_and_o 0, empty_o 1 (inputs idle), header/data 0.
- Reset mid-message: all state is cleared asynchronously; the partial message is dropped. Downstream must also be reset.
- Invariant (asserted): a source's header must stay constant across all beats of its message.

Optional Feature:
BP_CCE_HYBRID_MEM_ARB_FIXED_PRIO_EN
- Defined: port 0 (uncached) always wins in e_ready; last_r is removed. Starvation of port 1 is accepted.
- Undefined: round-robin as above.

Decomposition:
- Shared package bp_me_pkg gets:
  - typedef enum {e_arb_ready, e_arb_busy};
  - the constant for number of arbiter sources (2).
- Sub-module bp_cce_hybrid_credit_counter: up/down saturating counter with full_o/empty_o, reused by other hybrid pipes.
- Round-robin selection stays inline; it is 2-input.

Test Plan:
- uc single-beat uc_rd (last=1), coh idle, ready=1 -> mem_cmd_v_o same cycle, header equal to input, credits 0->1, state stays e_ready.
- Both valid every cycle, single-beat, after reset -> grants alternate uc, coh, uc, coh; with FIXED_PRIO_EN -> uc every cycle.
- uc 8-beat uc_wr, coh asserts valid at beat 2 -> beats 1–8 contiguous from uc with coh_ready 0; coh granted the cycle after last; credits +1 per message.
- credits_p=2, two messages accepted with no returns -> third message held (mem_cmd_v_o=0). credit_return_i pulse -> sent next cycle. Simultaneous accept + return -> count unchanged.
- mem_cmd_ready_and_i=0 for 5 cycles with coh presenting; uc becomes valid at cycle 2 -> output stays coh with stable header; uc waits.
- reset_n_i asserted mid-message (beat 3 of 8) -> outputs 0 immediately (async); after release, empty_o=1 and credits 0.
